// File: rtl/matrix_mode_sched_pkg.sv
// +--------------------------------------------------------------------+
// | matrix_mode_sched_pkg: shared FSM encoding and matrix geometry     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package matrix_mode_sched_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_BLANK  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam int c_ROWS = 5;
    localparam int c_COLS = 7;

endpackage

`default_nettype wire

// File: rtl/matrix_mode_sched_key_debounce.sv
// +--------------------------------------------------------------------+
// | key_debounce: 2-FF synchronizer, debounce filter, press pulse      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module key_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key,
    output logic o_press
);

    localparam int            CNT_W  = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    // Counter tracks consecutive samples that disagree with the accepted level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_cnt == c_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                    r_press <= r_sync2;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_press;

endmodule

`default_nettype wire

// File: rtl/matrix_mode_sched.sv
// +--------------------------------------------------------------------+
// | matrix_mode_sched: round-robin LED matrix source scheduler         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module matrix_mode_sched
    import matrix_mode_sched_pkg::*;
#(
    parameter int N_SRC        = 4,
    parameter int ROWS         = c_ROWS,
    parameter int COLS         = c_COLS,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int BLANK_CYC    = 50_000
) (
    input  logic                  CLOCK_50,
    input  logic                  rst_n,
    input  logic                  key_mode,
    input  logic                  key_off,
    input  logic [N_SRC*ROWS-1:0] src_row,
    input  logic [N_SRC*COLS-1:0] src_col,
    output logic [N_SRC-1:0]      enable,
    output logic [N_SRC-1:0]      mode_leds,
    output logic                  busy,
    output logic [ROWS-1:0]       row,
    output logic [COLS-1:0]       column
);

    localparam int                CUR_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int                BCNT_W = $clog2(BLANK_CYC + 1);
    localparam logic [CUR_W-1:0]  c_CUR_MAX  = CUR_W'(N_SRC - 1);
    localparam logic [BCNT_W-1:0] c_BLANK_LAST = BCNT_W'(BLANK_CYC - 1);

    logic              w_mode_ev;
    logic              w_off_ev;
    logic [CUR_W-1:0]  w_cur_inc;
    logic [N_SRC-1:0]  w_cur_oh;
    logic [N_SRC-1:0]  w_inc_oh;
    logic [ROWS-1:0]   w_row_sel;
    logic [COLS-1:0]   w_col_sel;

    state_t            r_state;
    logic [CUR_W-1:0]  r_cur;
    logic [BCNT_W-1:0] r_bcnt;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_mode (
        .clk     (CLOCK_50),
        .rst_n   (rst_n),
        .i_key   (key_mode),
        .o_press (w_mode_ev)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_off (
        .clk     (CLOCK_50),
        .rst_n   (rst_n),
        .i_key   (key_off),
        .o_press (w_off_ev)
    );

    assign w_cur_inc = (r_cur == c_CUR_MAX) ? '0 : r_cur + CUR_W'(1);
    assign w_cur_oh  = N_SRC'(1) << r_cur;
    assign w_inc_oh  = N_SRC'(1) << w_cur_inc;
    assign w_row_sel = src_row[int'(r_cur) * ROWS +: ROWS];
    assign w_col_sel = src_col[int'(r_cur) * COLS +: COLS];

    // Off takes priority over mode; a mode event always restarts the blank window
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            r_state   <= ST_OFF;
            r_cur     <= '0;
            r_bcnt    <= '0;
            enable    <= '0;
            mode_leds <= '0;
            busy      <= 1'b0;
            row       <= '0;
            column    <= '0;
        end else if (w_off_ev) begin
            r_state   <= ST_OFF;
            r_bcnt    <= '0;
            enable    <= '0;
            mode_leds <= '0;
            busy      <= 1'b0;
            row       <= '0;
            column    <= '0;
        end else if (w_mode_ev) begin
            r_state <= ST_BLANK;
            r_bcnt  <= '0;
            busy    <= 1'b1;
            row     <= '0;
            column  <= '0;
            if (r_state == ST_OFF) begin
                enable    <= w_cur_oh;
                mode_leds <= w_cur_oh;
            end else begin
                r_cur     <= w_cur_inc;
                enable    <= w_inc_oh;
                mode_leds <= w_inc_oh;
            end
        end else begin
            case (r_state)
                ST_BLANK: begin
                    if (r_bcnt == c_BLANK_LAST) begin
                        r_state <= ST_ACTIVE;
                        busy    <= 1'b0;
                        row     <= w_row_sel;
                        column  <= w_col_sel;
                    end else begin
                        r_bcnt <= r_bcnt + BCNT_W'(1);
                    end
                end
                ST_ACTIVE: begin
                    row    <= w_row_sel;
                    column <= w_col_sel;
                end
                ST_OFF: begin
                    enable    <= '0;
                    mode_leds <= '0;
                end
                default: r_state <= ST_OFF;
            endcase
        end
    end

endmodule

`default_nettype wire
